div_repsub: RTL and testbench

// - Sequential unsigned divider by repeated subtraction; inverse of the team's repeated-addition multiplier.
// - Shares its operand interface: one shared input bus, dividend then divisor on consecutive cycles.
// - Returns quotient and remainder with a one-cycle done strobe.
// - Sits beside the multiplier in the arithmetic block set; drives control-path scaling/normalisation.

---
 rtl/div_repsub_if.sv | 21 ++
 rtl/div_repsub.sv | 97 +++++++++
 tb/tb_div_repsub.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/div_repsub_if.sv
// Operand/result bundle shared with the repeated-addition multiplier.
// Optional divide-by-zero flag dz exists only when DIV_ZERO_FLAG_EN is defined.
interface div_repsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
`ifdef DIV_ZERO_FLAG_EN
  logic             dz;

  modport master (output start, din, input busy, done, quot, rem, dz);
  modport slave  (input start, din, output busy, done, quot, rem, dz);
`else
  modport master (output start, din, input busy, done, quot, rem);
  modport slave  (input start, din, output busy, done, quot, rem);
`endif
endinterface

// File: rtl/div_repsub.sv
// Sequential unsigned divider by repeated subtraction; dividend then divisor on din.
// Build macro DIV_ZERO_FLAG_EN adds the dz divide-by-zero flag output.
module div_repsub #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  div_repsub_if.slave bus
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LOAD_A = 5'b00010,
    LOAD_B = 5'b00100,
    SUB    = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy_r;
  logic             done_r;
  logic             b_zero;

  assign b_zero = (b == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      q      <= '0;
      r      <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= LOAD_A;
            busy_r <= 1'b1;
          end
        end
        LOAD_A: begin
          a     <= bus.din;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b     <= bus.din;
          r     <= a;
          q     <= '0;
          state <= SUB;
        end
        SUB: begin
          // Compare guards the subtract, so R never underflows and Q never wraps.
          if (!b_zero && (r >= b)) begin
            r <= r - b;
            q <= q + WIDTH'(1);
          end else begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state  <= LOAD_A;
            busy_r <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Results are visible only during the done strobe; divide-by-zero reports all ones.
  assign bus.quot = done_r ? (b_zero ? '1 : q) : '0;
  assign bus.rem  = done_r ? r : '0;

`ifdef DIV_ZERO_FLAG_EN
  assign bus.dz = done_r & b_zero;
`endif

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: directed corner cases plus random operands
// compared against a plain-arithmetic reference (a/b, a%b, latency 3+quotient).
module tb_div_repsub;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  div_repsub_if #(.WIDTH(W)) bus ();

  div_repsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Runs one division starting at a negedge with the FSM in IDLE or DONE.
  // Returns at the negedge where done is first seen high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    int           exp_lat;
    int           got_lat;
    bit           bad_wait;
    exp_q   = (b == 0) ? {W{1'b1}} : W'(a / b);
    exp_r   = (b == 0) ? a : W'(a % b);
    exp_lat = 3 + ((b == 0) ? 0 : int'(a / b));
    got_lat = -1;
    bad_wait = 1'b0;
    bus.start = 1'b1;
    bus.din   = a;
    for (int e = 0; e < 70000; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got_lat = e;
        break;
      end
      if (bus.busy !== 1'b1 || bus.quot !== '0 || bus.rem !== '0) bad_wait = 1'b1;
      bus.start = (noisy && e >= 1) ? 1'($urandom) : 1'b0;
      bus.din   = (e == 0) ? a : ((e == 1) ? b : W'($urandom));
    end
    checks++;
    if (got_lat !== exp_lat) begin
      errors++;
      $display("FAIL latency %0d/%0d: done after edge %0d, expected edge %0d", a, b, got_lat, exp_lat);
    end
    checks++;
    if (bad_wait) begin
      errors++;
      $display("FAIL wait_outputs %0d/%0d: busy or early quot/rem wrong while waiting, expected busy=1 quot=0 rem=0", a, b);
    end
    checks++;
    if (bus.quot !== exp_q) begin
      errors++;
      $display("FAIL quot %0d/%0d: got %0d expected %0d", a, b, bus.quot, exp_q);
    end
    checks++;
    if (bus.rem !== exp_r) begin
      errors++;
      $display("FAIL rem %0d/%0d: got %0d expected %0d", a, b, bus.rem, exp_r);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done %0d/%0d: got %b expected 0", a, b, bus.busy);
    end
`ifdef DIV_ZERO_FLAG_EN
    checks++;
    if (bus.dz !== (b == 0)) begin
      errors++;
      $display("FAIL dz %0d/%0d: got %b expected %b", a, b, bus.dz, (b == 0));
    end
`endif
  endtask

  // Leaves DONE with start low and checks the strobe lasted one cycle.
  task automatic finish_idle(input string tag);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quot !== '0 || bus.rem !== '0) begin
      errors++;
      $display("FAIL after_done %s: done=%b busy=%b quot=%0d rem=%0d expected all 0",
               tag, bus.done, bus.busy, bus.quot, bus.rem);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.din   = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quot !== '0 || bus.rem !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b quot=%0d rem=%0d expected all 0",
               bus.busy, bus.done, bus.quot, bus.rem);
    end
`ifdef DIV_ZERO_FLAG_EN
    checks++;
    if (bus.dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_dz: got %b expected 0", bus.dz);
    end
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    run_op(16'd100, 16'd7, 1'b0);
    finish_idle("100/7");
  endtask

  task automatic test_exact_and_unit();
    run_op(16'd42, 16'd6, 1'b0);
    finish_idle("42/6");
    run_op(16'd65535, 16'd1, 1'b0);
    finish_idle("65535/1");
  endtask

  task automatic test_small_dividend();
    run_op(16'd5, 16'd9, 1'b0);
    finish_idle("5/9");
    run_op(16'd0, 16'd3, 1'b0);
    finish_idle("0/3");
  endtask

  task automatic test_div_zero();
    run_op(16'd1234, 16'd0, 1'b0);
    finish_idle("1234/0");
  endtask

  task automatic test_back_to_back();
    run_op(16'd100, 16'd7, 1'b1);
    run_op(16'd50, 16'd5, 1'b1);
    run_op(16'd17, 16'd0, 1'b1);
    run_op(16'd3, 16'd3, 1'b0);
    finish_idle("back_to_back");
  endtask

  task automatic test_reset_mid_op();
    bus.start = 1'b1;
    bus.din   = 16'd1000;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.din = 16'd1;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_sub: got %b expected 1", bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quot !== '0 || bus.rem !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b quot=%0d rem=%0d expected all 0",
               bus.busy, bus.done, bus.quot, bus.rem);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_abort: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    run_op(16'd9, 16'd2, 1'b0);
    finish_idle("9/2");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           chain;
    for (int i = 0; i < 12; i++) begin
      a = W'($urandom_range(0, 500));
      b = W'($urandom_range(0, 40));
      chain = 1'($urandom);
      run_op(a, b, chain);
      if (!chain) finish_idle("random");
    end
    finish_idle("random_end");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact_and_unit();
    test_small_dividend();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
